morse_encoder: RTL and testbench

MORSE_ENCODER -- requirements
Module: morse_encoder

---
 rtl/morse_pkg.sv | 23 ++
 rtl/morse_lut.sv | 63 ++++++
 rtl/morse_encoder.sv | 108 ++++++++++
 tb/tb_morse_encoder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse encoder: symbol code constants, FSM state
// encoding and the code-to-pattern record.
package morse_pkg;

    localparam logic [5:0] CODE_DIGIT0 = 6'd26;
    localparam logic [5:0] CODE_WORD   = 6'd36;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MARK,
        GAP,
        CHAR_GAP,
        WORD_GAP
    } state_t;

    // Pattern is right-aligned and sent MSB-first from bit len-1; 1 = dash.
    typedef struct packed {
        logic [2:0] len;
        logic [4:0] pattern;
    } pattern_t;

endpackage

// File: rtl/morse_lut.sv
// Combinational code-to-pattern table. Digits 26..35 are only present when
// MORSE_DIGITS_EN is defined; otherwise they fall through as unsupported.
module morse_lut
    import morse_pkg::*;
(
    input  logic [5:0] code,
    output logic [2:0] len,
    output logic [4:0] pattern,
    output logic       valid
);

    pattern_t entry;

    always_comb begin
        entry = '{3'd0, 5'b00000};
        valid = 1'b1;
        case (code)
            6'd0:  entry = '{3'd2, 5'b00001};
            6'd1:  entry = '{3'd4, 5'b01000};
            6'd2:  entry = '{3'd4, 5'b01010};
            6'd3:  entry = '{3'd3, 5'b00100};
            6'd4:  entry = '{3'd1, 5'b00000};
            6'd5:  entry = '{3'd4, 5'b00010};
            6'd6:  entry = '{3'd3, 5'b00110};
            6'd7:  entry = '{3'd4, 5'b00000};
            6'd8:  entry = '{3'd2, 5'b00000};
            6'd9:  entry = '{3'd4, 5'b00111};
            6'd10: entry = '{3'd3, 5'b00101};
            6'd11: entry = '{3'd4, 5'b00100};
            6'd12: entry = '{3'd2, 5'b00011};
            6'd13: entry = '{3'd2, 5'b00010};
            6'd14: entry = '{3'd3, 5'b00111};
            6'd15: entry = '{3'd4, 5'b00110};
            6'd16: entry = '{3'd4, 5'b01101};
            6'd17: entry = '{3'd3, 5'b00010};
            6'd18: entry = '{3'd3, 5'b00000};
            6'd19: entry = '{3'd1, 5'b00001};
            6'd20: entry = '{3'd3, 5'b00001};
            6'd21: entry = '{3'd4, 5'b00001};
            6'd22: entry = '{3'd3, 5'b00011};
            6'd23: entry = '{3'd4, 5'b01001};
            6'd24: entry = '{3'd4, 5'b01011};
            6'd25: entry = '{3'd4, 5'b01100};
`ifdef MORSE_DIGITS_EN
            CODE_DIGIT0 + 6'd0: entry = '{3'd5, 5'b11111};
            CODE_DIGIT0 + 6'd1: entry = '{3'd5, 5'b01111};
            CODE_DIGIT0 + 6'd2: entry = '{3'd5, 5'b00111};
            CODE_DIGIT0 + 6'd3: entry = '{3'd5, 5'b00011};
            CODE_DIGIT0 + 6'd4: entry = '{3'd5, 5'b00001};
            CODE_DIGIT0 + 6'd5: entry = '{3'd5, 5'b00000};
            CODE_DIGIT0 + 6'd6: entry = '{3'd5, 5'b10000};
            CODE_DIGIT0 + 6'd7: entry = '{3'd5, 5'b11000};
            CODE_DIGIT0 + 6'd8: entry = '{3'd5, 5'b11100};
            CODE_DIGIT0 + 6'd9: entry = '{3'd5, 5'b11110};
`endif
            default: valid = 1'b0;
        endcase
    end

    assign len     = entry.len;
    assign pattern = entry.pattern;

endmodule

// File: rtl/morse_encoder.sv
// Morse keyer: accepts one symbol code at a time and keys it out with standard
// unit timing. Digit support is enabled by defining MORSE_DIGITS_EN.
module morse_encoder
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 25000000
) (
    input  logic       in_clk,
    input  logic       rst,
    input  logic       char_valid,
    input  logic [5:0] char_code,
    output logic       char_ready,
    output logic       key_out,
    output logic       busy,
    output logic       err
);

    localparam logic [31:0] UNIT_TC = 32'(UNIT_CYCLES - 1);

    state_t      state, next_state;
    logic [5:0]  code_q;
    logic [31:0] unit_cnt;
    logic [1:0]  unit_idx;
    logic [1:0]  last_unit;
    logic [2:0]  elem_idx;
    logic [2:0]  lut_len;
    logic [4:0]  lut_pattern;
    logic        lut_valid;
    logic        timed, unit_tc, elem_done, err_next;

    morse_lut u_lut (
        .code    (code_q),
        .len     (lut_len),
        .pattern (lut_pattern),
        .valid   (lut_valid)
    );

    assign char_ready = (state == IDLE);
    assign busy       = ~char_ready;
    assign timed      = (state == MARK) || (state == GAP) ||
                        (state == CHAR_GAP) || (state == WORD_GAP);
    assign unit_tc    = (unit_cnt == UNIT_TC);

    // last_unit is the final unit index of the current element or gap.
    always_comb begin
        next_state = state;
        err_next   = 1'b0;
        last_unit  = 2'd0;
        case (state)
            MARK:     last_unit = lut_pattern[elem_idx] ? 2'd2 : 2'd0;
            CHAR_GAP: last_unit = 2'd2;
            WORD_GAP: last_unit = 2'd3;
            default:  last_unit = 2'd0;
        endcase
        elem_done = timed && unit_tc && (unit_idx == last_unit);
        case (state)
            IDLE: if (char_valid) next_state = LOAD;
            LOAD: begin
                if (code_q == CODE_WORD) begin
                    next_state = WORD_GAP;
                end else if (lut_valid) begin
                    next_state = MARK;
                end else begin
                    next_state = IDLE;
                    err_next   = 1'b1;
                end
            end
            MARK:     if (elem_done) next_state = (elem_idx == 3'd0) ? CHAR_GAP : GAP;
            GAP:      if (elem_done) next_state = MARK;
            CHAR_GAP: if (elem_done) next_state = IDLE;
            WORD_GAP: if (elem_done) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Counters restart on every state change so back-to-back elements stay exact.
    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            code_q   <= 6'd0;
            unit_cnt <= 32'd0;
            unit_idx <= 2'd0;
            elem_idx <= 3'd0;
            key_out  <= 1'b0;
            err      <= 1'b0;
        end else begin
            state   <= next_state;
            key_out <= (next_state == MARK);
            err     <= err_next;
            if (state == IDLE && char_valid) code_q <= char_code;
            if (state == LOAD) begin
                elem_idx <= lut_len - 3'd1;
            end else if (state == GAP && next_state == MARK) begin
                elem_idx <= elem_idx - 3'd1;
            end
            if (!timed || next_state != state) begin
                unit_cnt <= 32'd0;
                unit_idx <= 2'd0;
            end else if (unit_tc) begin
                unit_cnt <= 32'd0;
                unit_idx <= unit_idx + 2'd1;
            end else begin
                unit_cnt <= unit_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_morse_encoder.sv
// Directed self-checking bench for morse_encoder with UNIT_CYCLES=4
// (1 unit = 4 cycles, 3 units = 12, 4 units = 16).
module tb_morse_encoder;

    logic       in_clk = 1'b0;
    logic       rst;
    logic       char_valid;
    logic [5:0] char_code;
    logic       char_ready;
    logic       key_out;
    logic       busy;
    logic       err;

    int checks   = 0;
    int failures = 0;
    int n;
    logic busy_ok;

    morse_encoder #(.UNIT_CYCLES(4)) dut (
        .in_clk     (in_clk),
        .rst        (rst),
        .char_valid (char_valid),
        .char_code  (char_code),
        .char_ready (char_ready),
        .key_out    (key_out),
        .busy       (busy),
        .err        (err)
    );

    always #5 in_clk = ~in_clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge with char_ready high; returns at the LOAD-cycle sample.
    task automatic apply_stimulus(input logic [5:0] code);
        char_code  = code;
        char_valid = 1'b1;
        @(posedge in_clk);
        @(negedge in_clk);
        char_valid = 1'b0;
    endtask

    // Counts negedge samples while key_out holds 'level' and the encoder is busy.
    task automatic count_key_run(input logic level, output int len);
        len = 0;
        while (key_out === level && char_ready === 1'b0 && len < 400) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            len++;
            @(negedge in_clk);
        end
    endtask

    initial begin
        rst        = 1'b0;
        char_valid = 1'b0;
        char_code  = 6'd0;
        repeat (2) @(negedge in_clk);
        check_output("reset_ready", char_ready, 1);
        check_output("reset_busy", busy, 0);
        check_output("reset_key", key_out, 0);
        check_output("reset_err", err, 0);
        rst = 1'b1;

        apply_stimulus(6'd4);
        check_output("E_load_key", key_out, 0);
        check_output("E_load_busy", busy, 1);
        @(negedge in_clk);
        count_key_run(1'b1, n);
        check_output("E_mark", n, 4);
        count_key_run(1'b0, n);
        check_output("E_chargap", n, 12);
        check_output("E_ready", char_ready, 1);

        busy_ok = 1'b1;
        apply_stimulus(6'd0);
        @(negedge in_clk);
        count_key_run(1'b1, n);
        check_output("A_dot", n, 4);
        count_key_run(1'b0, n);
        check_output("A_gap", n, 4);
        count_key_run(1'b1, n);
        check_output("A_dash", n, 12);
        count_key_run(1'b0, n);
        check_output("A_chargap", n, 12);
        check_output("A_ready", char_ready, 1);
        check_output("A_busy_throughout", busy_ok, 1);

        char_code  = 6'd19;
        char_valid = 1'b1;
        @(posedge in_clk);
        @(negedge in_clk);
        char_code = 6'd36;
        @(negedge in_clk);
        count_key_run(1'b1, n);
        check_output("T_dash", n, 12);
        count_key_run(1'b0, n);
        check_output("T_chargap", n, 12);
        check_output("T_idle_ready", char_ready, 1);
        check_output("T_idle_key", key_out, 0);
        @(negedge in_clk);
        check_output("space_accepted_busy", busy, 1);
        check_output("space_load_key", key_out, 0);
        char_valid = 1'b0;
        @(negedge in_clk);
        count_key_run(1'b0, n);
        check_output("space_wordgap", n, 16);
        check_output("space_ready", char_ready, 1);

        apply_stimulus(6'd45);
        check_output("bad_load_err", err, 0);
        check_output("bad_load_ready", char_ready, 0);
        @(negedge in_clk);
        check_output("bad_err_pulse", err, 1);
        check_output("bad_ready", char_ready, 1);
        check_output("bad_key", key_out, 0);
        @(negedge in_clk);
        check_output("bad_err_cleared", err, 0);
        check_output("bad_key_after", key_out, 0);

        apply_stimulus(6'd26);
`ifdef MORSE_DIGITS_EN
        @(negedge in_clk);
        for (int i = 0; i < 5; i++) begin
            count_key_run(1'b1, n);
            check_output($sformatf("zero_dash%0d", i), n, 12);
            count_key_run(1'b0, n);
            check_output($sformatf("zero_gap%0d", i), n, (i < 4) ? 4 : 12);
        end
        check_output("zero_ready", char_ready, 1);
`else
        @(negedge in_clk);
        check_output("zero_err_pulse", err, 1);
        check_output("zero_ready", char_ready, 1);
        check_output("zero_key", key_out, 0);
        @(negedge in_clk);
        check_output("zero_err_cleared", err, 0);
`endif

        apply_stimulus(6'd19);
        repeat (6) @(negedge in_clk);
        check_output("rst_middash_key", key_out, 1);
        #2 rst = 1'b0;
        #1;
        check_output("rst_async_key", key_out, 0);
        check_output("rst_async_ready", char_ready, 1);
        check_output("rst_async_busy", busy, 0);
        repeat (3) @(negedge in_clk);
        check_output("rst_hold_key", key_out, 0);
        check_output("rst_hold_ready", char_ready, 1);
        rst = 1'b1;
        apply_stimulus(6'd4);
        check_output("rst_E_load_busy", busy, 1);
        @(negedge in_clk);
        count_key_run(1'b1, n);
        check_output("rst_E_mark", n, 4);
        count_key_run(1'b0, n);
        check_output("rst_E_chargap", n, 12);
        check_output("rst_E_ready", char_ready, 1);
        repeat (3) @(negedge in_clk);
        check_output("rst_not_resumed_key", key_out, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
